// File: rtl/enigma_pkg.sv
// Shared rotor constants: alphabet size, position width, rotor type codes and notch letters.
package enigma_pkg;
  localparam int ALPHABET = 26;
  localparam int POS_W    = 5;
  localparam int TYPE_W   = 3;

  typedef enum logic [TYPE_W-1:0] {
    ROTOR_I    = 3'd0,
    ROTOR_II   = 3'd1,
    ROTOR_III  = 3'd2,
    ROTOR_IV   = 3'd3,
    ROTOR_V    = 3'd4,
    ROTOR_VI   = 3'd5,
    ROTOR_VII  = 3'd6,
    ROTOR_VIII = 3'd7
  } rotor_type_e;

  localparam int NOTCH_I   = 16;  // Q
  localparam int NOTCH_II  = 4;   // E
  localparam int NOTCH_III = 21;  // V
  localparam int NOTCH_IV  = 9;   // J
  localparam int NOTCH_V   = 25;  // Z
  localparam int NOTCH_Z   = 25;  // VI..VIII first notch
  localparam int NOTCH_M   = 12;  // VI..VIII second notch
endpackage

// File: rtl/rotor_notch_lut.sv
// Combinational turnover lookup: is a rotor of the given type sitting on one of its notches.
module rotor_notch_lut #(
  parameter int POS_W = enigma_pkg::POS_W
) (
  input  logic [enigma_pkg::TYPE_W-1:0] type_i,
  input  logic [POS_W-1:0]              pos_i,
  output logic                          at_notch_o
);
  import enigma_pkg::*;

  always_comb begin
    at_notch_o = 1'b0;
    case (rotor_type_e'(type_i))
      ROTOR_I:   at_notch_o = (pos_i == POS_W'(NOTCH_I));
      ROTOR_II:  at_notch_o = (pos_i == POS_W'(NOTCH_II));
      ROTOR_III: at_notch_o = (pos_i == POS_W'(NOTCH_III));
      ROTOR_IV:  at_notch_o = (pos_i == POS_W'(NOTCH_IV));
      ROTOR_V:   at_notch_o = (pos_i == POS_W'(NOTCH_V));
      ROTOR_VI, ROTOR_VII, ROTOR_VIII:
        at_notch_o = (pos_i == POS_W'(NOTCH_Z)) || (pos_i == POS_W'(NOTCH_M));
      default:   at_notch_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/rotor_stepper_n.sv
// N-rotor (3 or 4) stepping controller with double-step anomaly; rotor 3 is a fixed Greek wheel.
// Optional step counter output enabled by defining STEP_COUNT_EN.
module rotor_stepper_n #(
  parameter int NUM_ROTORS = 3,
  parameter int POS_W      = enigma_pkg::POS_W,
  parameter int ALPHABET   = enigma_pkg::ALPHABET
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [3*NUM_ROTORS-1:0]     rotor_type,
  input  logic [POS_W*NUM_ROTORS-1:0] rotor_start,
  input  logic                        rotate,
  output logic [POS_W*NUM_ROTORS-1:0] positions,
`ifdef STEP_COUNT_EN
  output logic [15:0]                 step_count,
`endif
  output logic                        step_done
);
  import enigma_pkg::*;

  localparam int TW = TYPE_W;
  typedef logic [POS_W-1:0] pos_t;

  pos_t [NUM_ROTORS-1:0] pos_q, pos_d;
  logic                  rotate_q, step_done_q, step_done_d, step_acc;
  logic [1:0]            notch;
  logic [NUM_ROTORS-1:0] step_en;

  // Only rotors 0 and 1 drive carries, so rotor 2/3 type slices go nowhere.
  logic unused_type;
  assign unused_type = ^rotor_type[3*NUM_ROTORS-1:2*TW];

  function automatic pos_t inc_mod(input pos_t p);
    return (p == pos_t'(ALPHABET-1)) ? '0 : p + pos_t'(1);
  endfunction

  function automatic pos_t reduce(input pos_t p);
    return (p >= pos_t'(ALPHABET)) ? p - pos_t'(ALPHABET) : p;
  endfunction

  assign step_acc = rotate & ~rotate_q;

  for (genvar g = 0; g < 2; g++) begin : g_notch
    rotor_notch_lut #(.POS_W(POS_W)) u_lut (
      .type_i    (rotor_type[TW*g +: TW]),
      .pos_i     (pos_q[g]),
      .at_notch_o(notch[g])
    );
  end

  always_comb begin
    // Carries use pre-step positions; rotor1 self-steps on its own notch (double-step).
    step_en    = '0;
    step_en[0] = 1'b1;
    step_en[1] = notch[0] | notch[1];
    step_en[2] = notch[1];
    for (int i = 0; i < NUM_ROTORS; i++) begin
      pos_d[i] = pos_q[i];
      if (load)
        pos_d[i] = reduce(rotor_start[POS_W*i +: POS_W]);
      else if (step_acc && step_en[i])
        pos_d[i] = inc_mod(pos_q[i]);
    end
    step_done_d = step_acc & ~load;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos_q       <= '0;
      rotate_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      rotate_q    <= rotate;
      step_done_q <= step_done_d;
    end
  end

  assign positions = pos_q;
  assign step_done = step_done_q;

`ifdef STEP_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)          cnt_d = '0;
    else if (step_acc) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign step_count = cnt_q;
`endif
endmodule

// File: tb/tb_rotor_stepper_n.sv
// Scoreboard bench: drives a 3-rotor and a 4-rotor instance in lockstep with directed vectors.
module tb_rotor_stepper_n;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        rotate = 1'b0;
  logic [8:0]  rtype = '0;
  logic [14:0] start = '0;
  logic [4:0]  r3_start = 5'd7;
  logic [14:0] pos3;
  logic [19:0] pos4;
  logic        sd3, sd4;
`ifdef STEP_COUNT_EN
  logic [15:0] cnt3, cnt4;
`endif

  always #5 clock = ~clock;

  rotor_stepper_n #(.NUM_ROTORS(3)) u3 (
    .clock(clock), .reset(reset), .load(load), .rotor_type(rtype),
    .rotor_start(start), .rotate(rotate), .positions(pos3),
`ifdef STEP_COUNT_EN
    .step_count(cnt3),
`endif
    .step_done(sd3)
  );

  rotor_stepper_n #(.NUM_ROTORS(4)) u4 (
    .clock(clock), .reset(reset), .load(load), .rotor_type({3'd7, rtype}),
    .rotor_start({r3_start, start}), .rotate(rotate), .positions(pos4),
`ifdef STEP_COUNT_EN
    .step_count(cnt4),
`endif
    .step_done(sd4)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [19:0] pos; int c; } exp_t;
  exp_t q3[$], q4[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] P(input int r2, input int r1, input int r0);
    return {5'(r2), 5'(r1), 5'(r0)};
  endfunction

  // Reference stepping for the long run (types fixed at runtime by rtype).
  function automatic logic nt(input logic [2:0] t, input logic [4:0] p);
    case (t)
      3'd0: return p == 5'd16;
      3'd1: return p == 5'd4;
      3'd2: return p == 5'd21;
      3'd3: return p == 5'd9;
      3'd4: return p == 5'd25;
      default: return (p == 5'd25) || (p == 5'd12);
    endcase
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [14:0] model(input logic [8:0] t, input logic [14:0] p);
    logic n0, n1;
    n0 = nt(t[2:0], p[4:0]);
    n1 = nt(t[5:3], p[9:5]);
    return {n1 ? inc26(p[14:10]) : p[14:10], (n0 | n1) ? inc26(p[9:5]) : p[9:5], inc26(p[4:0])};
  endfunction

  // Monitor: every step_done must match the oldest expectation, including its cycle.
  always @(negedge clock) begin
    if (sd3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL u3 spurious step_done at cycle %0d actual=1 required=0", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("u3 step positions", 32'(pos3), 32'(e.pos[14:0]));
        chk("u3 step_done cycle", cyc, e.c);
      end
    end
    if (sd4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL u4 spurious step_done at cycle %0d actual=1 required=0", cyc);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("u4 step positions", 32'(pos4), 32'(e.pos));
        chk("u4 step_done cycle", cyc, e.c);
      end
    end
  end

  task automatic do_load(input logic [8:0] t, input logic [14:0] s, input logic [14:0] exp);
    @(posedge clock); #1;
    rtype = t; start = s; load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    chk("u3 load", 32'(pos3), 32'(exp));
    chk("u4 load", 32'(pos4), 32'({r3_start, exp}));
`ifdef STEP_COUNT_EN
    chk("u3 count after load", 32'(cnt3), 0);
`endif
  endtask

  task automatic rot(input logic [14:0] exp);
    @(posedge clock); #1;
    rotate = 1'b1;
    q3.push_back('{pos: {5'd0, exp}, c: cyc + 1});
    q4.push_back('{pos: {r3_start, exp}, c: cyc + 1});
    @(posedge clock); #1;
    rotate = 1'b0;
  endtask

  localparam logic [8:0] T_STD = {3'd0, 3'd1, 3'd2};  // rotor2=I, rotor1=II, rotor0=III

  initial begin
    logic [14:0] m;
    repeat (3) @(posedge clock);
    #1;
    chk("reset u3 positions", 32'(pos3), 0);
    chk("reset u4 positions", 32'(pos4), 0);
    chk("reset u3 step_done", 32'(sd3), 0);
    chk("reset u4 step_done", 32'(sd4), 0);
    reset = 1'b0;

    do_load(T_STD, P(0, 0, 0), P(0, 0, 0));
    rot(P(0, 0, 1));                       // AAB

    do_load(T_STD, P(0, 3, 20), P(0, 3, 20));
    rot(P(0, 3, 21));                      // ADV
    rot(P(0, 4, 22));                      // AEW
    rot(P(1, 5, 23));                      // BFX double-step

    do_load({3'd0, 3'd1, 3'd0}, P(0, 0, 25), P(0, 0, 25));
    rot(P(0, 0, 0));                       // type I wraps at Z without carry

    do_load({3'd0, 3'd1, 3'd5}, P(0, 0, 11), P(0, 0, 11));
    rot(P(0, 0, 12));
    rot(P(0, 1, 13));                      // VI carries off M
    do_load({3'd0, 3'd1, 3'd5}, P(0, 0, 25), P(0, 0, 25));
    rot(P(0, 1, 0));                       // VI carries off Z

    do_load(T_STD, P(26, 31, 30), P(0, 5, 4));

    // Rotate held high: one step only.
    do_load(T_STD, P(0, 0, 0), P(0, 0, 0));
    @(posedge clock); #1;
    rotate = 1'b1;
    q3.push_back('{pos: {5'd0, P(0, 0, 1)}, c: cyc + 1});
    q4.push_back('{pos: {r3_start, P(0, 0, 1)}, c: cyc + 1});
    repeat (4) @(posedge clock);
    #1 rotate = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk("held rotate single step", 32'(pos3), 32'(P(0, 0, 1)));

    // Load beats a simultaneous rotate edge.
    @(posedge clock); #1;
    start = P(2, 3, 4); load = 1'b1; rotate = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    chk("load+rotate u3", 32'(pos3), 32'(P(2, 3, 4)));
    chk("load+rotate u4", 32'(pos4), 32'({r3_start, P(2, 3, 4)}));
    repeat (2) @(posedge clock);
    #1 rotate = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk("load+rotate no later step", 32'(pos3), 32'(P(2, 3, 4)));

    // Long run: Greek wheel stays put.
    do_load(T_STD, P(0, 0, 0), P(0, 0, 0));
    m = P(0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      m = model(T_STD, m);
      rot(m);
    end
    @(posedge clock); #1;
    chk("30 steps u3", 32'(pos3), 32'(P(0, 1, 4)));
    chk("30 steps u4 greek", 32'(pos4[19:15]), 7);
    chk("30 steps u4", 32'(pos4[14:0]), 32'(P(0, 1, 4)));

`ifdef STEP_COUNT_EN
    do_load(T_STD, P(0, 0, 0), P(0, 0, 0));
    m = P(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      m = model(T_STD, m);
      rot(m);
    end
    @(posedge clock); #1;
    chk("u3 count 5", 32'(cnt3), 5);
    chk("u4 count 5", 32'(cnt4), 5);
    do_load(T_STD, P(0, 0, 0), P(0, 0, 0));
    chk("u4 count after load", 32'(cnt4), 0);
    rot(P(0, 0, 1));
    rot(P(0, 0, 2));
`endif

    // Reset overrides load and a rotate edge in the same cycle.
    do_load(T_STD, P(3, 4, 5), P(3, 4, 5));
    @(posedge clock); #1;
    reset = 1'b1; load = 1'b1; rotate = 1'b1; start = P(9, 9, 9);
    @(posedge clock); #1;
    chk("mid reset u3 positions", 32'(pos3), 0);
    chk("mid reset u4 positions", 32'(pos4), 0);
    chk("mid reset u3 step_done", 32'(sd3), 0);
`ifdef STEP_COUNT_EN
    chk("mid reset u3 count", 32'(cnt3), 0);
    chk("mid reset u4 count", 32'(cnt4), 0);
`endif
    reset = 1'b0; load = 1'b0; rotate = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk("scoreboard drained", q3.size() + q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/rotor_stepper_n.md
Name: rotor_stepper_n

Overview:
- Parametrised successor to the three-rotor stepping controller.
- Holds window positions for NUM_ROTORS rotors and loads start positions on command.
- Advances the rotors once per rotate edge, using per-type turnover notches (including the double-notch types VI-VIII) and the middle-rotor double-step anomaly.
- Feeds rotor positions to the substitution datapath. Supports 3-rotor (M3) and 4-rotor (M4, non-stepping Greek wheel) machines.

Parameters:
- NUM_ROTORS, 3: rotor count, legal values 3 or 4. Index 0 is the rightmost (fast) rotor. Index 3 is the Greek wheel and never steps.
- POS_W, 5: position width.
- ALPHABET, 26: position modulus.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  when high, latch rotor_start into positions.
- rotor_type  in  3*NUM_ROTORS  type per rotor, 3 bits each, slice i = rotor i; 0..7 = I..VIII. Slice 3 is ignored.
- rotor_start  in  POS_W*NUM_ROTORS  start position per rotor.
- rotate  in  1  step request; rising-edge detected.
- positions  out  POS_W*NUM_ROTORS  current window position per rotor (0=A..25=Z).
- step_done  out  1  one-cycle pulse in the cycle positions show the stepped values.

Behaviour:
- Reset (synchronous, active-high): positions = 0, step_done = 0, internal rotate_q = 0.
- Edge detect:
  - rotate_q <= rotate every cycle.
  - A step is accepted in cycle n when rotate=1 and rotate_q=0.
  - positions update at the clock edge ending cycle n, and step_done=1 in cycle n+1.
  - Holding rotate high yields exactly one step.
- Notch (turnover) positions: I=16(Q), II=4(E), III=21(V), IV=9(J), V=25(Z), VI/VII/VIII = 25(Z) and 12(M).
- Stepping rule, evaluated on pre-step positions:
  - rotor0 always steps.
  - rotor1 steps if rotor0 is at its notch OR rotor1 is at its notch (double-step).
  - rotor2 steps if rotor1 is at its notch.
  - rotor3, when present, never steps.
- Arithmetic: increment mod ALPHABET (25 -> 0). Loaded values of 26..31 are reduced mod 26 on load.
- load:
  - positions <= rotor_start (reduced) at the next edge, with no step_done.
  - load and an accepted step in the same cycle: load wins, the step is discarded, and rotate_q still updates.
- Reset asserted mid-sequence overrides load and step in that cycle.
- step_done is never high in two consecutive cycles.

Optional Feature:
- STEP_COUNT_EN defined:
  - Adds output step_count [15:0].
  - Cleared by reset and by load.
  - Incremented at the same edge as every accepted step; wraps 65535 -> 0.
- Not defined: port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package enigma_pkg: ALPHABET, POS_W, rotor type encoding constants (ROTOR_I..ROTOR_VIII), notch position constants.
- One sub-module, rotor_notch_lut: combinational (type, position) -> at_notch. Instantiated for rotor0 and rotor1 only.

Test Plan:
- Load types {2:I,1:II,0:III}, start AAA; one rotate -> positions AAB, step_done one pulse one cycle after the edge.
- Same types, load ADU; three rotates -> ADV, AEW, BFX (double-step).
- Rotor0 type I loaded at Z(25); rotate -> rotor0=A(0), rotor1 unchanged. Rotor0 type VI at L; rotate -> M with no carry; rotate -> N with rotor1 +1.
- rotate held high 4 cycles -> exactly one step and one step_done pulse. load and rotate edge in the same cycle -> positions = start, no step_done.
- NUM_ROTORS=4, rotor3 loaded with 7; 30 rotates -> rotor3 still 7, rotors 0-2 advance per the stepping rules.
- STEP_COUNT_EN: 5 rotates -> step_count=5; load -> 0; reset asserted mid-sequence -> all outputs 0 in the next cycle.
